tb_arr_frame_unpacker: RTL and testbench

// - Receive-side counterpart of the test-beam array counter readout.
// - Pops 32-bit words from the readout FIFO and parses counter frames of the form

---
 rtl/tb_arr_pkg.sv | 18 +
 rtl/tb_arr_snap_ram.sv | 22 ++
 rtl/tb_arr_frame_unpacker.sv | 127 ++++++++++++
 tb/tb_tb_arr_frame_unpacker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_arr_pkg.sv
// Shared counter-frame definition for the test-beam array readout link.
// Used by both the transmitter and the receive-side unpacker.
package tb_arr_pkg;

  localparam int unsigned NUM_CNT = 256;
  localparam int unsigned AW      = $clog2(NUM_CNT);

  localparam logic [15:0] HDR_TAG = 16'hA5A5;
  localparam logic [15:0] TRL_TAG = 16'h5A5A;
  localparam logic [31:0] TRL_WORD = {TRL_TAG, 16'(NUM_CNT)};

  localparam logic [AW-1:0] IDX_LAST = AW'(NUM_CNT - 1);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_TRAILER = 2'd2;

endpackage

// File: rtl/tb_arr_snap_ram.sv
// Ping-pong snapshot store: two banks of counter words.
// Simple dual-port, registered read.
module tb_arr_snap_ram
  import tb_arr_pkg::*;
(
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW:0]   waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW:0]   raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [2*NUM_CNT];

  always_ff @(posedge clk_i) begin
    if (we_i)
      mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/tb_arr_frame_unpacker.sv
// Receive-side counter frame parser: pops the readout FIFO, checks
// header/trailer and commits good frames into a ping-pong snapshot.
module tb_arr_frame_unpacker
  import tb_arr_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          fifo_empty_i,
  input  logic [31:0]   fifo_data_i,
  output logic          fifo_rd_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o,
  output logic          frame_done_o,
  output logic [15:0]   frame_seq_o,
  output logic [15:0]   frame_cnt_o,
  output logic          seq_err_o,
  output logic          sync_err_o,
  output logic          trl_err_o,
  input  logic          err_clr_i
);

  logic          wv;
  logic [1:0]    state;
  logic [AW-1:0] idx;
  logic          bank;
  logic [15:0]   seq_w;
  logic          have_frame;
  logic          rd_ok;
  logic [31:0]   ram_q;

  logic is_hdr;
  logic is_trl;
  logic wr_en;
  logic commit;
  logic trl_bad;
  logic sync_set;
  logic seq_gap;

  assign fifo_rd_o = !fifo_empty_i && !rst_i;

  assign is_hdr  = fifo_data_i[31:16] == HDR_TAG;
  assign is_trl  = fifo_data_i == TRL_WORD;
  assign seq_gap = have_frame &&
                   (seq_w != frame_seq_o + 16'd1);

  always_comb begin
    wr_en    = 1'b0;
    commit   = 1'b0;
    trl_bad  = 1'b0;
    sync_set = 1'b0;
    if (wv) begin
      case (state)
        ST_HUNT:    sync_set = !is_hdr;
        ST_PAYLOAD: wr_en    = 1'b1;
        ST_TRAILER: begin
          commit  = is_trl;
          trl_bad = !is_trl;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wv           <= 1'b0;
      state        <= ST_HUNT;
      idx          <= '0;
      bank         <= 1'b0;
      seq_w        <= '0;
      have_frame   <= 1'b0;
      rd_ok        <= 1'b0;
      frame_done_o <= 1'b0;
      frame_seq_o  <= '0;
      frame_cnt_o  <= '0;
      seq_err_o    <= 1'b0;
      sync_err_o   <= 1'b0;
      trl_err_o    <= 1'b0;
    end else begin
      wv           <= fifo_rd_o;
      frame_done_o <= commit;
      // read data is undefined until the first committed bank is read
      rd_ok        <= have_frame;
      if (wv) begin
        case (state)
          ST_HUNT: begin
            if (is_hdr) begin
              seq_w <= fifo_data_i[15:0];
              idx   <= '0;
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            idx <= idx + 1'b1;
            if (idx == IDX_LAST)
              state <= ST_TRAILER;
          end
          default: state <= ST_HUNT;
        endcase
      end
      if (commit) begin
        bank        <= ~bank;
        frame_seq_o <= seq_w;
        frame_cnt_o <= frame_cnt_o + 16'd1;
        have_frame  <= 1'b1;
      end
      seq_err_o  <= (commit && seq_gap) ||
                    (seq_err_o && !err_clr_i);
      sync_err_o <= sync_set ||
                    (sync_err_o && !err_clr_i);
      trl_err_o  <= trl_bad ||
                    (trl_err_o && !err_clr_i);
    end
  end

  tb_arr_snap_ram u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i ({~bank, idx}),
    .wdata_i (fifo_data_i),
    .raddr_i ({bank, rd_addr_i}),
    .rdata_o (ram_q)
  );

  assign rd_data_o = rd_ok ? ram_q : 32'd0;

endmodule

// File: tb/tb_tb_arr_frame_unpacker.sv
// Randomized bench for the counter frame unpacker, checked
// against a frame-level model of the word stream.
module tb_tb_arr_frame_unpacker;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        fifo_empty_i;
  logic [31:0] fifo_data_i;
  logic        fifo_rd_o;
  logic [7:0]  rd_addr_i;
  logic [31:0] rd_data_o;
  logic        frame_done_o;
  logic [15:0] frame_seq_o;
  logic [15:0] frame_cnt_o;
  logic        seq_err_o;
  logic        sync_err_o;
  logic        trl_err_o;
  logic        err_clr_i;

  always #5 clk = ~clk;

  tb_arr_frame_unpacker dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_o    (fifo_rd_o),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .frame_done_o (frame_done_o),
    .frame_seq_o  (frame_seq_o),
    .frame_cnt_o  (frame_cnt_o),
    .seq_err_o    (seq_err_o),
    .sync_err_o   (sync_err_o),
    .trl_err_o    (trl_err_o),
    .err_clr_i    (err_clr_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q[$];
  logic [31:0] unit[$];
  int pops      = 0;
  int bad_pops  = 0;
  int pulses    = 0;
  int thr_mode  = 0;
  bit thr       = 1'b0;

  // reference state
  logic [15:0] m_cnt;
  logic [15:0] m_seq;
  bit          m_sync, m_trl, m_serr, m_have;
  logic [31:0] m_mem [256];
  int          m_pulses;

  // non-FWFT FIFO: data appears the cycle after the strobe
  always @(posedge clk) begin
    if (fifo_rd_o) begin
      pops++;
      if (fifo_empty_i || q.size() == 0)
        bad_pops++;
      else
        fifo_data_i <= q.pop_front();
    end
  end

  always @(negedge clk)
    if (frame_done_o) pulses++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    fifo_empty_i = (q.size() == 0) ||
                   (thr_mode == 1 && thr) ||
                   (thr_mode == 2 && $urandom_range(0, 1) == 1);
    thr = ~thr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_seq = 0;
    m_sync = 0; m_trl = 0; m_serr = 0; m_have = 0;
    m_pulses = pulses;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    q.delete();
    thr_mode = 0;
    repeat (3) tick();
    rst_i = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic add_garbage(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (w[31:16] == 16'hA5A5) w[31] = 1'b0;
      unit.push_back(w);
    end
  endtask

  task automatic add_frame(input logic [15:0] seq,
                           input logic [31:0] trl,
                           input bit pat);
    unit.push_back({16'hA5A5, seq});
    for (int i = 0; i < 256; i++)
      unit.push_back(pat ? 32'h100 + 32'(i) : $urandom);
    unit.push_back(trl);
  endtask

  // walk the word list as whole frames: header, 256 words, trailer
  task automatic model_run();
    int i = 0;
    logic [15:0] s;
    while (i < unit.size()) begin
      if (unit[i][31:16] != 16'hA5A5) begin
        m_sync = 1;
        i++;
      end else begin
        s = unit[i][15:0];
        if (unit[i+257] == 32'h5A5A0100) begin
          if (m_have && s != m_seq + 16'd1) m_serr = 1;
          for (int k = 0; k < 256; k++) m_mem[k] = unit[i+1+k];
          m_seq = s;
          m_cnt = m_cnt + 16'd1;
          m_have = 1;
          m_pulses++;
        end else begin
          m_trl = 1;
        end
        i += 258;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20000) begin
      tick();
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 0);
    repeat (4) tick();
  endtask

  task automatic send();
    int p0 = pops;
    int len = unit.size();
    model_run();
    foreach (unit[i]) q.push_back(unit[i]);
    unit.delete();
    drain();
    chk("pop_count", 32'(pops - p0), 32'(len));
  endtask

  task automatic rd_chk(input logic [7:0] a);
    rd_addr_i = a;
    tick();
    chk($sformatf("rd[%0h]", a), rd_data_o,
        m_have ? m_mem[a] : 32'd0);
  endtask

  task automatic check_state();
    chk("frame_cnt", {16'd0, frame_cnt_o}, {16'd0, m_cnt});
    chk("frame_seq", {16'd0, frame_seq_o}, {16'd0, m_seq});
    chk("sync_err", {31'd0, sync_err_o}, {31'd0, m_sync});
    chk("trl_err", {31'd0, trl_err_o}, {31'd0, m_trl});
    chk("seq_err", {31'd0, seq_err_o}, {31'd0, m_serr});
    chk("pulses", 32'(pulses), 32'(m_pulses));
    chk("no_pop_empty", 32'(bad_pops), 0);
    rd_chk(8'h00);
    rd_chk(8'hFF);
    repeat (4) rd_chk(8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [15:0] s;
    logic [31:0] t;
    int p0;
    rst_i = 1'b1;
    fifo_empty_i = 1'b1;
    fifo_data_i = '0;
    rd_addr_i = '0;
    err_clr_i = 1'b0;
    model_reset();
    @(negedge clk);
    repeat (3) tick();
    chk("rst_rd_strobe", {31'd0, fifo_rd_o}, 0);
    rst_i = 1'b0;
    model_reset();
    tick();
    chk("rst_done", {31'd0, frame_done_o}, 0);
    check_state();

    // clean frame with counter pattern
    add_frame(16'h0001, 32'h5A5A0100, 1);
    send();
    check_state();
    rd_chk(8'h37);
    chk("clean_37", rd_data_o, 32'h137);

    // garbage then frame, then a bad-trailer frame
    do_reset();
    for (int i = 0; i < 3; i++) unit.push_back(32'hDEADBEEF);
    add_frame(16'h0001, 32'h5A5A0100, 1);
    send();
    check_state();
    add_frame(16'h0002, 32'h5A5A00FF, 0);
    send();
    check_state();
    rd_chk(8'h37);
    chk("badtrl_37", rd_data_o, 32'h137);

    // sequence gap plus all flags, then clear
    do_reset();
    add_garbage(2);
    add_frame(16'h0005, 32'h5A5A0100, 0);
    add_frame(16'h0006, 32'h5A5A00FF, 0);
    add_frame(16'h0007, 32'h5A5A0100, 0);
    send();
    check_state();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    m_sync = 0; m_trl = 0; m_serr = 0;
    tick();
    check_state();

    // throttled FIFO: empty toggling every cycle
    do_reset();
    thr_mode = 1;
    add_frame(16'h0003, 32'h5A5A0100, 0);
    send();
    thr_mode = 0;
    check_state();

    // reset in the middle of the payload
    do_reset();
    p0 = pops;
    add_frame(16'h0008, 32'h5A5A0100, 0);
    foreach (unit[i]) q.push_back(unit[i]);
    unit.delete();
    for (int n = 0; n < 2000 && pops - p0 < 101; n++) tick();
    chk("midframe_pops", {31'd0, (pops - p0) >= 101}, 1);
    do_reset();
    check_state();
    add_frame(16'h0009, 32'h5A5A0100, 0);
    send();
    check_state();
    chk("one_commit", {16'd0, frame_cnt_o}, 1);

    // random traffic
    do_reset();
    for (int it = 0; it < 8; it++) begin
      thr_mode = $urandom_range(0, 2);
      add_garbage($urandom_range(0, 2));
      s = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                      : m_seq + 16'd1;
      t = 32'h5A5A0100;
      if ($urandom_range(0, 3) == 0)
        t = t ^ (32'd1 << $urandom_range(0, 31));
      add_frame(s, t, 0);
      send();
      thr_mode = 0;
      check_state();
      if ($urandom_range(0, 2) == 0) begin
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        m_sync = 0; m_trl = 0; m_serr = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
